fetch_decoder: RTL

Sequential instruction fetch/decode front end for the byte-coded CPU. It reads variable-length instructions (opcode byte plus 0..MAX_LEN-1 argument bytes) from a synchronous-read instruction memory and decodes the opcode into a one-hot command flag vector. It presents each complete instruction to the execute stage over a valid/ready handshake, and accepts PC redirects from the execute stage for taken jumps. It replaces the purely combinational opcode lookup and adds fetch sequencing, operand assembly, illegal-opcode reporting and back-pressure.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/op_lut.sv | 27 ++
 rtl/fetch_decoder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the byte-coded CPU front end: opcodes, flag bit
// positions, instruction sizes and the fetch FSM state encoding.
package cpu_pkg;

    localparam logic [7:0] OP_MOV = 8'd11;
    localparam logic [7:0] OP_ADD = 8'd18;
    localparam logic [7:0] OP_CMP = 8'd67;
    localparam logic [7:0] OP_JMP = 8'd74;
    localparam logic [7:0] OP_JEQ = 8'd69;
    localparam logic [7:0] OP_JGG = 8'd71;

    localparam int F_MOV = 5;
    localparam int F_ADD = 4;
    localparam int F_CMP = 3;
    localparam int F_JMP = 2;
    localparam int F_JEQ = 1;
    localparam int F_JGG = 0;

    localparam logic [1:0] SZ_MOV = 2'd3;
    localparam logic [1:0] SZ_ADD = 2'd1;
    localparam logic [1:0] SZ_CMP = 2'd1;
    localparam logic [1:0] SZ_JMP = 2'd2;
    localparam logic [1:0] SZ_JEQ = 2'd2;
    localparam logic [1:0] SZ_JGG = 2'd2;
    localparam logic [1:0] SZ_ILL = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_OP,
        S_ARG,
        S_ISSUE
    } state_t;

endpackage

// File: rtl/op_lut.sv
// Combinational opcode table: opcode byte to one-hot command flags, table
// instruction size and an illegal-opcode indication.
module op_lut
    import cpu_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [5:0] flags,
    output logic [1:0] size,
    output logic       illegal
);

    always_comb begin
        flags   = '0;
        size    = SZ_ILL;
        illegal = 1'b0;
        case (opcode)
            OP_MOV: begin flags[F_MOV] = 1'b1; size = SZ_MOV; end
            OP_ADD: begin flags[F_ADD] = 1'b1; size = SZ_ADD; end
            OP_CMP: begin flags[F_CMP] = 1'b1; size = SZ_CMP; end
            OP_JMP: begin flags[F_JMP] = 1'b1; size = SZ_JMP; end
            OP_JEQ: begin flags[F_JEQ] = 1'b1; size = SZ_JEQ; end
            OP_JGG: begin flags[F_JGG] = 1'b1; size = SZ_JGG; end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_decoder.sv
// Sequential fetch/decode front end: reads variable-length instructions from a
// synchronous-read memory and issues them to execute over valid/ready.
module fetch_decoder
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                MAX_LEN  = 3,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int               SZ_W     = $clog2(MAX_LEN + 1),
    localparam int               ARG_W    = 8 * (MAX_LEN - 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [5:0]        cmd_flags,
    output logic [SZ_W-1:0]   cmd_size,
    output logic [ARG_W-1:0]  cmd_args,
    output logic [ADDR_W-1:0] cmd_pc,
    output logic              cmd_illegal,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_pc,
    output state_t            state
);

    logic [ADDR_W-1:0] pc;
    logic [SZ_W-1:0]   cnt;
    logic [5:0]        lut_flags;
    logic [1:0]        lut_size;
    logic              lut_illegal;
    logic [SZ_W-1:0]   dec_size;

    op_lut u_op_lut (
        .opcode  (mem_rdata),
        .flags   (lut_flags),
        .size    (lut_size),
        .illegal (lut_illegal)
    );

    always_comb begin
        dec_size = SZ_W'(lut_size);
        if (int'(lut_size) > MAX_LEN) dec_size = SZ_W'(MAX_LEN);
    end

    // Handshake: cmd_valid rises only once the whole instruction is captured;
    // cmd_* then hold until a cycle with cmd_valid && cmd_ready, and cmd_valid
    // never drops without that transfer unless a redirect or reset discards it.
    // mem_en/mem_addr are registered one cycle ahead: the address set here is
    // on the bus next cycle and its data returns the cycle after that.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            cnt         <= '0;
            mem_en      <= 1'b0;
            mem_addr    <= '0;
            cmd_valid   <= 1'b0;
            cmd_flags   <= '0;
            cmd_size    <= '0;
            cmd_args    <= '0;
            cmd_pc      <= '0;
            cmd_illegal <= 1'b0;
        end else if (redir_valid && state != S_IDLE) begin
            pc        <= redir_pc;
            state     <= S_REQ;
            mem_en    <= 1'b1;
            mem_addr  <= redir_pc;
            cmd_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state    <= S_REQ;
                        mem_en   <= 1'b1;
                        mem_addr <= pc;
                    end
                end
                S_REQ: begin
                    // The first argument byte is requested before the opcode
                    // is known so that 2-byte instructions need no extra cycle.
                    state    <= S_OP;
                    mem_en   <= 1'b1;
                    mem_addr <= pc + ADDR_W'(1);
                end
                S_OP: begin
                    cmd_flags   <= lut_flags;
                    cmd_size    <= dec_size;
                    cmd_illegal <= lut_illegal;
                    cmd_pc      <= pc;
                    cmd_args    <= '0;
                    cnt         <= SZ_W'(1);
                    if (dec_size == SZ_W'(1)) begin
                        mem_en    <= 1'b0;
                        cmd_valid <= 1'b1;
                        state     <= S_ISSUE;
                    end else begin
                        state    <= S_ARG;
                        mem_en   <= (int'(dec_size) > 2);
                        mem_addr <= pc + ADDR_W'(2);
                    end
                end
                S_ARG: begin
                    cmd_args[8*(int'(cnt)-1) +: 8] <= mem_rdata;
                    if (cnt == cmd_size - SZ_W'(1)) begin
                        mem_en    <= 1'b0;
                        cmd_valid <= 1'b1;
                        state     <= S_ISSUE;
                    end else begin
                        cnt      <= cnt + SZ_W'(1);
                        mem_en   <= (int'(cnt) + 3 <= int'(cmd_size));
                        mem_addr <= pc + ADDR_W'(cnt) + ADDR_W'(2);
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        pc        <= pc + ADDR_W'(cmd_size);
                        state     <= S_REQ;
                        mem_en    <= 1'b1;
                        mem_addr  <= pc + ADDR_W'(cmd_size);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
